gshare_pht: RTL and testbench
=============================

// Module: gshare_pht
// PURPOSE
//  Consumer end of the global history register. Folds the GHR history vector with the fetch PC
//  into a gshare index and reads a pattern history table (PHT) of 2-bit saturating counters.
//  Returns a registered taken/not-taken prediction the cycle after a request.
//  Also trains the counters from resolved branches. Sits in fetch beside the GHR; train port driven from EX.
// PARAMETERS
//  HISTORY_SIZE  64  width of history vector from GHR (bit 0 = newest outcome)
//  INDEX_BITS    10  log2 of PHT entry count (1024 counters)
//  PC_LSB        2   lowest PC bit used in index (word-aligned fetch)
// PORTS
//  clk             in   1             clock; all state updates on rising edge
//  rst             in   1             asynchronous, active-high reset
//  o_ready         out  1             1 = table initialised, requests/updates accepted
//  i_req_valid     in   1             prediction request this cycle
//  i_req_pc        in   32            fetch PC of branch
//  i_history       in   HISTORY_SIZE  current GHR contents
//  o_pred_valid    out  1             registered: prediction for previous-cycle request
//  o_pred_taken    out  1             registered: predicted direction
//  o_pred_index    out  INDEX_BITS    registered: PHT index used; carried down pipe for training
//  i_upd_valid     in   1             resolved branch training event
//  i_upd_index     in   INDEX_BITS    index returned earlier on o_pred_index
//  i_upd_taken     in   1             actual outcome
// BEHAVIOUR
//  - Reset (async assert): FSM->INIT, sweep ptr=0; o_ready=0, o_pred_valid=0, o_pred_taken=0,
//    o_pred_index=0. Deassert is sampled by clk; sweep starts next edge.
//  - FSM INIT: one entry written per cycle to 2'b01 (weakly not-taken), ptr 0..2^INDEX_BITS-1.
//    After writing last entry -> RUN; o_ready=1 from the following cycle. INIT = 2^INDEX_BITS cycles.
//    In INIT, requests are ignored (o_pred_valid stays 0) and updates are dropped.
//  - FSM RUN: stays until rst. rst asserted mid-RUN or mid-INIT restarts INIT at ptr 0.
//    Counters are not preserved.
//  - Hash: pad history with zeros to a multiple of INDEX_BITS and XOR all INDEX_BITS-wide
//    chunks -> fold. idx = fold ^ i_req_pc[PC_LSB +: INDEX_BITS]. Combinational; no state.
//  - Predict: latency 1. Edge with i_req_valid & RUN: o_pred_valid<=1, o_pred_index<=idx,
//    o_pred_taken<=ctr_next[idx][1]. Otherwise o_pred_valid<=0; taken/index hold their value.
//  - Train: edge with i_upd_valid & RUN applies ctr<=sat(ctr±1): taken increments, capped at 3;
//    not-taken decrements, floored at 0. Only the entry at i_upd_index changes.
//  - Same-cycle request + update to equal index: the prediction uses the post-update value ctr_next
//    (write-to-read bypass). A different index has no interaction.
//  - One request and one update per cycle max; no backpressure beyond o_ready.
//  - History is sampled only on request cycles; GHR shift timing is the caller's concern.
// TESTING
//  1 Reset: pulse rst mid-clock -> outputs 0 immediately. o_ready rises exactly 1024 cycles after
//    first post-reset edge. A request during INIT gives o_pred_valid=0.
//  2 Fresh table: pc=0x00400010, history=0 -> next cycle o_pred_valid=1, o_pred_index=0x004,
//    o_pred_taken=0.
//  3 Saturation: 3 taken updates to idx 0x004 -> predict taken, ctr=3. 4th taken leaves 3.
//    Then 2 not-taken -> ctr=1, predicts 0. 3 more not-taken -> ctr=0, no underflow.
//  4 Fold: HISTORY_SIZE=64, INDEX_BITS=10, history=64'h1, pc=0 -> index 0x001.
//    history bit 60 set (bit 0 of the 7th, zero-padded chunk) -> index 0x001.
//    history=64'h401 -> index 0x000 (bits 0 and 10 cancel).
//  5 Bypass: ctr[0x004]=1. Same cycle: taken update to 0x004 + request mapping to 0x004
//    -> o_pred_taken=1. Repeat with a different index -> old value predicted.
//  6 Reset mid-RUN: train idx 0x004 to 3, assert rst -> after re-init, predict at 0x004 = 0.

Source files
------------

// File: rtl/gshare_pht.sv
// rtl/gshare_pht.sv - gshare pattern history table with folded global history and trainable 2-bit counters
// Sweeps the table to weakly-not-taken after reset, then serves 1-cycle predictions and training updates.
module gshare_pht #(
  parameter int HISTORY_SIZE = 64,
  parameter int INDEX_BITS   = 10,
  parameter int PC_LSB       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    o_ready,
  input  logic                    i_req_valid,
  input  logic [31:0]             i_req_pc,
  input  logic [HISTORY_SIZE-1:0] i_history,
  output logic                    o_pred_valid,
  output logic                    o_pred_taken,
  output logic [INDEX_BITS-1:0]   o_pred_index,
  input  logic                    i_upd_valid,
  input  logic [INDEX_BITS-1:0]   i_upd_index,
  input  logic                    i_upd_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int NCHUNK  = (HISTORY_SIZE + INDEX_BITS - 1) / INDEX_BITS;
  localparam int PAD_W   = NCHUNK * INDEX_BITS;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic                  taken_q, taken_d;
  logic [INDEX_BITS-1:0] index_q, index_d;

  logic [1:0]            pht_q [ENTRIES];
  logic                  pht_we;
  logic [INDEX_BITS-1:0] pht_waddr;
  logic [1:0]            pht_wdata;

  logic [PAD_W-1:0]      hist_pad;
  logic [INDEX_BITS-1:0] fold;
  logic [INDEX_BITS-1:0] req_idx;
  logic [1:0]            upd_cur;
  logic [1:0]            upd_ctr;
  logic [1:0]            pred_ctr;
  logic                  unused_pc;

  assign unused_pc = ^i_req_pc;

  always_comb begin
    hist_pad = '0;
    hist_pad[HISTORY_SIZE-1:0] = i_history;
    fold = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      fold = fold ^ hist_pad[c*INDEX_BITS +: INDEX_BITS];
    end
  end

  assign req_idx = fold ^ i_req_pc[PC_LSB +: INDEX_BITS];

  always_comb begin
    upd_cur = pht_q[i_upd_index];
    upd_ctr = upd_cur;
    if (i_upd_taken) begin
      if (upd_cur != 2'd3) upd_ctr = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'd0) upd_ctr = upd_cur - 2'd1;
    end
  end

  // Same-cycle update to the requested entry is forwarded so the prediction sees the trained value.
  assign pred_ctr = (i_upd_valid && (i_upd_index == req_idx)) ? upd_ctr : pht_q[req_idx];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    valid_d   = 1'b0;
    taken_d   = taken_q;
    index_d   = index_q;
    pht_we    = 1'b0;
    pht_waddr = i_upd_index;
    pht_wdata = upd_ctr;
    case (state_q)
      ST_INIT: begin
        pht_we    = 1'b1;
        pht_waddr = ptr_q;
        pht_wdata = 2'b01;
        ptr_d     = ptr_q + INDEX_BITS'(1);
        if (ptr_q == {INDEX_BITS{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN: begin
        pht_we = i_upd_valid;
        if (i_req_valid) begin
          valid_d = 1'b1;
          index_d = req_idx;
          taken_d = pred_ctr[1];
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      taken_q <= taken_d;
      index_q <= index_d;
    end
  end

  // Table contents need no reset: the INIT sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (pht_we) pht_q[pht_waddr] <= pht_wdata;
  end

  assign o_ready      = (state_q == ST_RUN);
  assign o_pred_valid = valid_q;
  assign o_pred_taken = taken_q;
  assign o_pred_index = index_q;

endmodule

// File: tb/tb_gshare_pht.sv
// tb/tb_gshare_pht.sv - self-checking bench for gshare_pht against an array-based reference model
module tb_gshare_pht;

  localparam int HS = 64;
  localparam int IB = 10;
  localparam int PL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          o_ready;
  logic          i_req_valid;
  logic [31:0]   i_req_pc;
  logic [HS-1:0] i_history;
  logic          o_pred_valid;
  logic          o_pred_taken;
  logic [IB-1:0] o_pred_index;
  logic          i_upd_valid;
  logic [IB-1:0] i_upd_index;
  logic          i_upd_taken;

  int n_checks = 0;
  int n_errors = 0;
  int model [1024];
  logic          e_valid;
  logic          e_taken;
  logic [IB-1:0] e_index;

  gshare_pht #(.HISTORY_SIZE(HS), .INDEX_BITS(IB), .PC_LSB(PL)) dut (
    .clk          (clk),
    .rst          (rst),
    .o_ready      (o_ready),
    .i_req_valid  (i_req_valid),
    .i_req_pc     (i_req_pc),
    .i_history    (i_history),
    .o_pred_valid (o_pred_valid),
    .o_pred_taken (o_pred_taken),
    .o_pred_index (o_pred_index),
    .i_upd_valid  (i_upd_valid),
    .i_upd_index  (i_upd_index),
    .i_upd_taken  (i_upd_taken)
  );

  always #5 clk = ~clk;

  function automatic logic [IB-1:0] ref_idx(input logic [31:0] pc, input logic [HS-1:0] h);
    int v;
    v = int'((pc >> PL) % 1024);
    for (int i = 0; i < HS; i++) begin
      if (h[i]) v = v ^ (1 << (i % IB));
    end
    return v[IB-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic idle_inputs();
    i_req_valid = 1'b0;
    i_req_pc    = '0;
    i_history   = '0;
    i_upd_valid = 1'b0;
    i_upd_index = '0;
    i_upd_taken = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) model[i] = 1;
    e_valid = 1'b0;
    e_taken = 1'b0;
    e_index = '0;
  endtask

  task automatic cycle(input logic req, input logic [31:0] pc, input logic [HS-1:0] h,
                       input logic upd, input logic [IB-1:0] ui, input logic ut);
    i_req_valid = req;
    i_req_pc    = pc;
    i_history   = h;
    i_upd_valid = upd;
    i_upd_index = ui;
    i_upd_taken = ut;
    if (upd) model[ui] = ut ? ((model[ui] >= 3) ? 3 : model[ui] + 1)
                            : ((model[ui] <= 0) ? 0 : model[ui] - 1);
    e_valid = req;
    if (req) begin
      e_index = ref_idx(pc, h);
      e_taken = (model[e_index] >= 2);
    end
    @(posedge clk);
    #1;
    chk("pred_valid", 32'(o_pred_valid), 32'(e_valid));
    chk("pred_index", 32'(o_pred_index), 32'(e_index));
    chk("pred_taken", 32'(o_pred_taken), 32'(e_taken));
    idle_inputs();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    i_req_valid = 1'b1;
    i_req_pc    = 32'h0000_0010;
    i_upd_valid = 1'b1;
    i_upd_index = 10'h004;
    i_upd_taken = 1'b1;
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1 || n == 512) chk("init_req_ignored", 32'(o_pred_valid), 32'd0);
      if (o_ready) break;
    end
    chk("ready_latency", 32'(n), 32'd1024);
    idle_inputs();
  endtask

  initial begin
    logic          rq;
    logic [31:0]   pc;
    logic [HS-1:0] h;
    logic [IB-1:0] ui;

    rst = 1'b0;
    idle_inputs();
    model_reset();

    // Reset pulse mid-clock; outputs clear without waiting for an edge
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_valid", 32'(o_pred_valid), 32'd0);
    chk("rst_taken", 32'(o_pred_taken), 32'd0);
    chk("rst_index", 32'(o_pred_index), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready();

    // Fresh table
    cycle(1'b1, 32'h0040_0010, '0, 1'b0, '0, 1'b0);
    chk("fresh_index_const", 32'(o_pred_index), 32'h004);
    chk("fresh_taken_const", 32'(o_pred_taken), 32'd0);

    // Saturation up and down at index 0x004
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 10'h004, 1'b1);
    cycle(1'b1, 32'h10, '0, 1'b0, '0, 1'b0);
    chk("sat3_taken_const", 32'(o_pred_taken), 32'd1);
    cycle(1'b0, '0, '0, 1'b1, 10'h004, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, '0, 1'b1, 10'h004, 1'b0);
    cycle(1'b1, 32'h10, '0, 1'b0, '0, 1'b0);
    chk("sat_down_taken_const", 32'(o_pred_taken), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 10'h004, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 10'h004, 1'b1);

    // Fold boundary cases
    cycle(1'b1, 32'h0, 64'h1, 1'b0, '0, 1'b0);
    chk("fold_bit0", 32'(o_pred_index), 32'h001);
    cycle(1'b1, 32'h0, 64'h1 << 60, 1'b0, '0, 1'b0);
    chk("fold_bit60", 32'(o_pred_index), 32'h001);
    cycle(1'b1, 32'h0, 64'h401, 1'b0, '0, 1'b0);
    chk("fold_cancel", 32'(o_pred_index), 32'h000);

    // Write-to-read bypass, then no interaction on a different index
    cycle(1'b1, 32'h10, '0, 1'b1, 10'h004, 1'b1);
    chk("bypass_same_const", 32'(o_pred_taken), 32'd1);
    cycle(1'b1, 32'h24, '0, 1'b1, 10'h008, 1'b1);
    chk("bypass_other_const", 32'(o_pred_taken), 32'd0);

    // Randomised traffic with frequent index collisions
    for (int k = 0; k < 400; k++) begin
      rq = ($urandom_range(0, 3) != 0);
      pc = $urandom;
      if ($urandom_range(0, 1) == 1) pc = pc & 32'h0000_003C;
      h = ($urandom_range(0, 1) == 1) ? '0 : {$urandom, $urandom};
      ui = ($urandom_range(0, 1) == 1) ? ref_idx(pc, h) : IB'($urandom_range(0, 15));
      cycle(rq, pc, h, $urandom_range(0, 1) == 1, ui, $urandom_range(0, 1) == 1);
    end

    // Reset mid-RUN discards trained counters
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 10'h004, 1'b1);
    cycle(1'b1, 32'h10, '0, 1'b0, '0, 1'b0);
    chk("pre_rerst_taken", 32'(o_pred_taken), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rerst_ready", 32'(o_ready), 32'd0);
    chk("rerst_valid", 32'(o_pred_valid), 32'd0);
    chk("rerst_taken", 32'(o_pred_taken), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_ready();
    cycle(1'b1, 32'h10, '0, 1'b0, '0, 1'b0);
    chk("post_rerst_taken", 32'(o_pred_taken), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
